// File: rtl/mbe_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: FSM states, digit control, digit count.
// Combinational helpers only; no latency and no backpressure of its own.
package mbe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic two;
        logic neg;
    } booth_ctl_t;

    function automatic booth_ctl_t booth_decode(input logic [2:0] trip);
        booth_ctl_t c;
        c.zero = (trip == 3'b000) || (trip == 3'b111);
        c.two  = (trip == 3'b011) || (trip == 3'b100);
        c.neg  = trip[2] && !c.zero;
        return c;
    endfunction

    // Unsigned operands need one extra digit to absorb the zero-extended top bit.
    function automatic int unsigned num_digits(input int unsigned w, input logic tc);
        return tc ? (w / 2) : (w / 2 + 1);
    endfunction

endpackage

// File: rtl/mbe_pp_sel.sv
// Booth triplet decode and 0/+-A/+-2A partial-product select, W+2 bits wide.
// Purely combinational: zero latency, no backpressure.
module mbe_pp_sel #(
    parameter int W = 8
) (
    input  logic [W+1:0] mcand,
    input  logic [2:0]   trip,
    output logic [W+1:0] pp
);
    import mbe_pkg::*;

    booth_ctl_t   ctl;
    logic [W+1:0] mag;

    always_comb begin
        ctl = booth_decode(trip);
        mag = ctl.two ? {mcand[W:0], 1'b0} : mcand;
        if (ctl.zero) begin
            pp = '0;
        end else if (ctl.neg) begin
            pp = -mag;
        end else begin
            pp = mag;
        end
    end

endmodule

// File: rtl/mbe_seq_mul.sv
// Sequential radix-4 Booth multiplier, one digit per cycle; latency W/2+1 (tc=1) or W/2+2 (tc=0) from accept.
// Accepts only in IDLE; holds the product in DONE until out_ready.
module mbe_seq_mul #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           tc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product
);
    import mbe_pkg::*;

    localparam int XW = W + 2;
    localparam int AW = 2 * W + 2;
    localparam int CW = $clog2(W / 2 + 2);

    state_t          state, state_nxt;
    logic [XW-1:0]   a_q, b_q;
    logic            tc_q;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   acc;

    logic            accept;
    logic            last;
    logic [XW:0]     b_ext;
    logic [2:0]      trip;
    logic [XW-1:0]   pp;
    logic [AW-1:0]   pp_ext;
    logic [XW-1:0]   a_in, b_in;

    assign accept = in_valid & in_ready;
    assign last   = (cnt == CW'(num_digits(W, tc_q)));
    assign a_in   = tc ? {{2{a[W-1]}}, a} : {2'b00, a};
    assign b_in   = tc ? {{2{b[W-1]}}, b} : {2'b00, b};

    // Appending b[-1]=0 lets digit i be read as bits [2i+2:2i] of b_ext.
    assign b_ext  = {b_q, 1'b0};
    assign trip   = 3'(b_ext >> {cnt, 1'b0});
    assign pp_ext = {{W{pp[XW-1]}}, pp} << {cnt, 1'b0};

    mbe_pp_sel #(.W(W)) u_pp_sel (
        .mcand (a_q),
        .trip  (trip),
        .pp    (pp)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // RUN spends one cycle past the last digit so the latency matches the fixed schedule.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last)      state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            tc_q <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
        end else if (accept) begin
            a_q  <= a_in;
            b_q  <= b_in;
            tc_q <= tc;
            cnt  <= '0;
            acc  <= '0;
        end else if (state == ST_RUN && !last) begin
            acc  <= acc + pp_ext;
            cnt  <= cnt + CW'(1);
        end
    end

    assign product = acc[2*W-1:0];

endmodule
